// File: rtl/led_pattern_ctrl_pkg.sv
// Shared types and constants for the LED pattern controller.
// Mode encodings here are the single source for the RTL and the bench.
package led_pattern_ctrl_pkg;

   localparam int unsigned MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      MODE_COUNT  = 2'd0,
      MODE_CHASE  = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_HOLD   = 2'd3
   } mode_e;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_e;

   // Mode sequence stepped by button[0].
   function automatic mode_e next_mode(input mode_e m);
      mode_e n;
      case (m)
         MODE_COUNT:  n = MODE_CHASE;
         MODE_CHASE:  n = MODE_BOUNCE;
         MODE_BOUNCE: n = MODE_HOLD;
         default:     n = MODE_COUNT;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/led_pattern_ctrl_debounce.sv
// Per-button synchroniser, saturating debounce counter and press pulse.
// Buttons are active-low; only a stable 1->0 transition yields a pulse.
module led_pattern_debounce #(
   parameter int unsigned DEBOUNCE_BITS = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic button_i,
   output logic press_o
);

   localparam logic [DEBOUNCE_BITS-1:0] CNT_MAX = '1;

   logic                     sync1_q;
   logic                     sync2_q;
   logic                     stable_q;
   logic                     stable_d;
   logic                     press_q;
   logic                     press_d;
   logic [DEBOUNCE_BITS-1:0] cnt_q;
   logic [DEBOUNCE_BITS-1:0] cnt_d;

   // Count consecutive samples that disagree with the stable value.
   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      press_d  = 1'b0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_MAX) begin
            stable_d = ~stable_q;
            press_d  = stable_q;
         end else begin
            cnt_d = cnt_q + DEBOUNCE_BITS'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         stable_q <= 1'b1;
         cnt_q    <= '0;
         press_q  <= 1'b0;
      end else begin
         sync1_q  <= button_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         press_q  <= press_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED pattern controller: debounced buttons select a mode, a free-running
// prescaler steps the pattern, and the LEDs mirror the pattern register.
module led_pattern_ctrl
   import led_pattern_ctrl_pkg::*;
#(
   parameter int unsigned LED_WIDTH      = 6,
   parameter int unsigned BUTTON_COUNT   = 5,
   parameter int unsigned TICK_BITS      = 21,
   parameter int unsigned DEBOUNCE_BITS  = 16,
   parameter int unsigned LED_ACTIVE_LOW = 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [BUTTON_COUNT-1:0] button,
   output logic [LED_WIDTH-1:0]    led,
   output logic [MODE_W-1:0]       mode,
   output logic                    tick
);

   localparam logic [TICK_BITS-1:0] TICK_MAX = '1;
   localparam logic [LED_WIDTH-1:0] LED_RST  = (LED_ACTIVE_LOW != 0) ? '1 : '0;

   logic [BUTTON_COUNT-1:0] press;
   logic [TICK_BITS-1:0]    presc_q;
   logic [TICK_BITS-1:0]    presc_d;
   logic                    tick_q;
   logic                    tick_d;
   mode_e                   mode_q;
   mode_e                   mode_d;
   dir_e                    dir_q;
   dir_e                    dir_d;
   logic [LED_WIDTH-1:0]    pattern_q;
   logic [LED_WIDTH-1:0]    pattern_d;
   logic [LED_WIDTH-1:0]    led_q;
   logic [LED_WIDTH-1:0]    led_d;
   logic                    mode_ev;
   logic                    sel_ev;
   logic [LED_WIDTH-1:0]    sel_pat;

   for (genvar b = 0; b < int'(BUTTON_COUNT); b++) begin : g_db
      led_pattern_debounce #(
         .DEBOUNCE_BITS(DEBOUNCE_BITS)
      ) u_db (
         .clk      (clk),
         .reset_n  (reset_n),
         .button_i (button[b]),
         .press_o  (press[b])
      );
   end

   // tick_q is high exactly while the prescaler sits at its maximum.
   always_comb begin
      presc_d = presc_q + TICK_BITS'(1);
      tick_d  = (presc_d == TICK_MAX);
   end

   // Lowest-index select button wins; indices past the LED range load 0.
   always_comb begin
      mode_ev = press[0];
      sel_ev  = 1'b0;
      sel_pat = '0;
      for (int k = int'(BUTTON_COUNT) - 1; k >= 1; k--) begin
         if (press[k]) begin
            sel_ev  = 1'b1;
            sel_pat = (k <= int'(LED_WIDTH)) ? (LED_WIDTH'(1) << (k - 1)) : '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode_q <= MODE_COUNT;
      end else begin
         mode_q <= mode_d;
      end
   end

   always_comb begin
      mode_d = mode_q;
      if (mode_ev) begin
         mode_d = next_mode(mode_q);
      end else if (sel_ev) begin
         mode_d = MODE_HOLD;
      end
   end

   // Pattern update: mode advance reload, then select load, then tick step.
   always_comb begin
      pattern_d = pattern_q;
      dir_d     = dir_q;
      if (mode_ev) begin
         case (mode_d)
            MODE_COUNT:  pattern_d = '0;
            MODE_CHASE:  pattern_d = LED_WIDTH'(1);
            MODE_BOUNCE: begin
               pattern_d = LED_WIDTH'(1);
               dir_d     = DIR_LEFT;
            end
            default: ;
         endcase
      end else if (sel_ev) begin
         pattern_d = sel_pat;
      end else if (tick_q) begin
         case (mode_q)
            MODE_COUNT:  pattern_d = pattern_q + LED_WIDTH'(1);
            MODE_CHASE:  pattern_d = (pattern_q << 1) | (pattern_q >> (LED_WIDTH - 1));
            MODE_BOUNCE: begin
               if (LED_WIDTH > 1) begin
                  if (dir_q == DIR_LEFT) begin
                     if (pattern_q[LED_WIDTH-1]) begin
                        dir_d     = DIR_RIGHT;
                        pattern_d = pattern_q >> 1;
                     end else begin
                        pattern_d = pattern_q << 1;
                     end
                  end else begin
                     if (pattern_q[0]) begin
                        dir_d     = DIR_LEFT;
                        pattern_d = pattern_q << 1;
                     end else begin
                        pattern_d = pattern_q >> 1;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
      led_d = (LED_ACTIVE_LOW != 0) ? ~pattern_d : pattern_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_q   <= '0;
         tick_q    <= 1'b0;
         dir_q     <= DIR_LEFT;
         pattern_q <= '0;
         led_q     <= LED_RST;
      end else begin
         presc_q   <= presc_d;
         tick_q    <= tick_d;
         dir_q     <= dir_d;
         pattern_q <= pattern_d;
         led_q     <= led_d;
      end
   end

   assign led  = led_q;
   assign mode = mode_q;
   assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with a fast prescaler and short debounce.
module tb_led_pattern_ctrl;
   import led_pattern_ctrl_pkg::*;

   localparam int unsigned LW = 6;
   localparam int unsigned BC = 5;
   localparam int B = 1120;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [BC-1:0] button;
   logic [LW-1:0] led;
   logic [1:0]    mode;
   logic          tick;

   int n_pass  = 0;
   int n_total = 0;
   int t       = 0;

   typedef struct {
      int            u;
      logic [BC-1:0] btn;
      mode_e         m;
      logic [LW-1:0] pat;
   } vec_t;

   vec_t tbl[$];

   always #5 clk = ~clk;

   led_pattern_ctrl #(
      .LED_WIDTH      (LW),
      .BUTTON_COUNT   (BC),
      .TICK_BITS      (4),
      .DEBOUNCE_BITS  (3),
      .LED_ACTIVE_LOW (1)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .button  (button),
      .led     (led),
      .mode    (mode),
      .tick    (tick)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0d)", name, act, exp, t);
   endtask

   task automatic check_state(input string name, input mode_e m, input logic [LW-1:0] pat);
      logic [LW-1:0] nled;
      nled = ~pat;
      check({name, ".mode"}, 32'(mode), 32'(m));
      check({name, ".led"}, 32'(led), 32'(nled));
   endtask

   task automatic step();
      @(negedge clk);
      t++;
   endtask

   task automatic to_t(input int target);
      while (t < target) step();
   endtask

   function automatic vec_t mk(input int u, input logic [BC-1:0] b, input mode_e m,
                               input logic [LW-1:0] p);
      vec_t v;
      v.u = u; v.btn = b; v.m = m; v.pat = p;
      return v;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      tbl.push_back(mk(  0, 5'h1E, MODE_COUNT,  6'd6));
      tbl.push_back(mk( 10, 5'h1E, MODE_COUNT,  6'd6));
      tbl.push_back(mk( 11, 5'h1E, MODE_CHASE,  6'd1));
      tbl.push_back(mk( 15, 5'h1E, MODE_CHASE,  6'd1));
      tbl.push_back(mk( 16, 5'h1E, MODE_CHASE,  6'd2));
      tbl.push_back(mk( 20, 5'h1F, MODE_CHASE,  6'd2));
      tbl.push_back(mk( 32, 5'h1F, MODE_CHASE,  6'd4));
      tbl.push_back(mk( 48, 5'h1F, MODE_CHASE,  6'd8));
      tbl.push_back(mk( 64, 5'h1F, MODE_CHASE,  6'd16));
      tbl.push_back(mk( 80, 5'h1F, MODE_CHASE,  6'd32));
      tbl.push_back(mk( 96, 5'h1F, MODE_CHASE,  6'd1));
      tbl.push_back(mk(100, 5'h1E, MODE_CHASE,  6'd1));
      tbl.push_back(mk(110, 5'h1E, MODE_CHASE,  6'd1));
      tbl.push_back(mk(111, 5'h1E, MODE_BOUNCE, 6'd1));
      tbl.push_back(mk(112, 5'h1E, MODE_BOUNCE, 6'd2));
      tbl.push_back(mk(120, 5'h1F, MODE_BOUNCE, 6'd2));
      tbl.push_back(mk(128, 5'h1F, MODE_BOUNCE, 6'd4));
      tbl.push_back(mk(144, 5'h1F, MODE_BOUNCE, 6'd8));
      tbl.push_back(mk(160, 5'h1F, MODE_BOUNCE, 6'd16));
      tbl.push_back(mk(176, 5'h1F, MODE_BOUNCE, 6'd32));
      tbl.push_back(mk(192, 5'h1F, MODE_BOUNCE, 6'd16));
      tbl.push_back(mk(208, 5'h1F, MODE_BOUNCE, 6'd8));
      tbl.push_back(mk(224, 5'h1F, MODE_BOUNCE, 6'd4));
      tbl.push_back(mk(240, 5'h1F, MODE_BOUNCE, 6'd2));
      tbl.push_back(mk(256, 5'h1F, MODE_BOUNCE, 6'd1));
      tbl.push_back(mk(272, 5'h1F, MODE_BOUNCE, 6'd2));
      tbl.push_back(mk(280, 5'h17, MODE_BOUNCE, 6'd2));
      tbl.push_back(mk(287, 5'h1F, MODE_BOUNCE, 6'd2));
      tbl.push_back(mk(292, 5'h17, MODE_BOUNCE, 6'd4));
      tbl.push_back(mk(299, 5'h1F, MODE_BOUNCE, 6'd4));
      tbl.push_back(mk(304, 5'h17, MODE_BOUNCE, 6'd8));
      tbl.push_back(mk(311, 5'h1F, MODE_BOUNCE, 6'd8));
      tbl.push_back(mk(320, 5'h1F, MODE_BOUNCE, 6'd16));
      tbl.push_back(mk(330, 5'h17, MODE_BOUNCE, 6'd16));
      tbl.push_back(mk(336, 5'h17, MODE_BOUNCE, 6'd32));
      tbl.push_back(mk(339, 5'h1F, MODE_BOUNCE, 6'd32));
      tbl.push_back(mk(340, 5'h1F, MODE_BOUNCE, 6'd32));
      tbl.push_back(mk(341, 5'h1F, MODE_HOLD,   6'd4));
      tbl.push_back(mk(352, 5'h1F, MODE_HOLD,   6'd4));
      tbl.push_back(mk(370, 5'h1F, MODE_HOLD,   6'd4));

      reset_n = 1'b0;
      button  = '1;
      repeat (3) @(negedge clk);
      check_state("reset", MODE_COUNT, 6'd0);
      check("reset.tick", 32'(tick), 32'd0);
      reset_n = 1'b1;
      t = 0;

      // Free-running count: tick every 16 clocks, pattern wraps after 63.
      for (int i = 1; i <= B; i++) begin
         step();
         check("run.tick", 32'(tick), ((t % 16) == 15) ? 32'd1 : 32'd0);
         check_state("run", MODE_COUNT, 6'((t / 16) % 64));
      end

      foreach (tbl[i]) begin
         to_t(B + tbl[i].u);
         check_state($sformatf("vec%0d", i), tbl[i].m, tbl[i].pat);
         button = tbl[i].btn;
      end

      // button[0] and button[2] events land in the tick cycle.
      to_t(B + 373);
      button = 5'h1A;
      to_t(B + 383);
      check("coinc.tick", 32'(tick), 32'd1);
      check_state("coinc.pre", MODE_HOLD, 6'd4);
      to_t(B + 384);
      check_state("coinc.post", MODE_COUNT, 6'd0);
      to_t(B + 393);
      button = 5'h1F;
      to_t(B + 399);
      check_state("coinc.hold", MODE_COUNT, 6'd0);
      to_t(B + 400);
      check_state("coinc.count", MODE_COUNT, 6'd1);

      // button[1] and button[4] together, also coincident with a tick.
      to_t(B + 405);
      button = 5'h0D;
      to_t(B + 415);
      check("sel.tick", 32'(tick), 32'd1);
      check_state("sel.pre", MODE_COUNT, 6'd1);
      to_t(B + 416);
      check_state("sel.post", MODE_HOLD, 6'd1);
      to_t(B + 425);
      button = 5'h1F;
      to_t(B + 432);
      check_state("sel.hold", MODE_HOLD, 6'd1);

      // Reset in the middle of a press discards it.
      to_t(B + 440);
      button = 5'h1E;
      to_t(B + 446);
      reset_n = 1'b0;
      #1;
      check_state("midrst", MODE_COUNT, 6'd0);
      check("midrst.tick", 32'(tick), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      t = 0;
      to_t(3);
      button = 5'h1F;
      to_t(12);
      check_state("postrst", MODE_COUNT, 6'd0);
      to_t(15);
      check("postrst.tick", 32'(tick), 32'd1);
      to_t(16);
      check_state("postrst.step", MODE_COUNT, 6'd1);
      to_t(30);
      check_state("postrst.late", MODE_COUNT, 6'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
